// File: rtl/cpu_debug_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : cpu_debug_mem_arbiter
// Purpose : Sequences and arbitrates the single-port OCI debug RAM between the
//           JTAG debug path and the CPU Avalon debug-memory slave.
// Revision: 1.0 - initial release
// ============================================================================
module cpu_debug_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [37:0]       jdo,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam logic [2:0] c_IDLE         = 3'd0;
  localparam logic [2:0] c_CPU_WR       = 3'd1;
  localparam logic [2:0] c_CPU_RD       = 3'd2;
  localparam logic [2:0] c_CPU_RD_DATA  = 3'd3;
  localparam logic [2:0] c_JTAG_WR      = 3'd4;
  localparam logic [2:0] c_JTAG_RD      = 3'd5;
  localparam logic [2:0] c_JTAG_RD_DATA = 3'd6;

  localparam logic c_GRANT_CPU  = 1'b0;
  localparam logic c_GRANT_JTAG = 1'b1;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_mon_a;
  logic [DATA_W-1:0] r_mon_d;
  logic              r_jtag_pend;
  logic              r_jtag_wr;
  logic [DATA_W-1:0] r_jtag_wdata;
  logic              r_last_grant;
  logic              r_error;

  logic [2:0] w_next_state;
  logic       w_grant_valid;
  logic       w_grant_jtag;
  logic       w_cpu_req;
  logic       w_acc_a;
  logic       w_acc_na;
  logic       w_acc_b;
  logic       w_any_pulse;
  logic       w_multi_pulse;
  logic       w_drop;
  logic       w_queue;
  logic       w_jtag_done;
  logic       w_unused;

  assign w_cpu_req = avs_read | avs_write;

  // Intake priority: ocimem_a > no_action_a > ocimem_b; nothing is taken while a JTAG op is pending.
  assign w_acc_a  = take_action_ocimem_a & ~r_jtag_pend;
  assign w_acc_na = take_no_action_ocimem_a & ~take_action_ocimem_a & ~r_jtag_pend;
  assign w_acc_b  = take_action_ocimem_b & ~take_action_ocimem_a & ~take_no_action_ocimem_a
                    & ~r_jtag_pend;

  assign w_any_pulse   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign w_multi_pulse = (take_action_ocimem_a & take_no_action_ocimem_a)
                       | (take_action_ocimem_a & take_action_ocimem_b)
                       | (take_no_action_ocimem_a & take_action_ocimem_b);
  assign w_drop        = r_jtag_pend ? w_any_pulse : w_multi_pulse;

  assign w_queue     = (w_acc_a & jdo[34]) | w_acc_na | w_acc_b;
  assign w_jtag_done = (r_state == c_JTAG_WR) | (r_state == c_JTAG_RD_DATA);

  assign w_unused = ^{jdo[37:35], jdo[2:0]};

  always_comb begin
    w_next_state  = r_state;
    w_grant_valid = 1'b0;
    w_grant_jtag  = 1'b0;
    case (r_state)
      c_IDLE: begin
        w_grant_valid = w_cpu_req | r_jtag_pend;
        w_grant_jtag  = r_jtag_pend & (~w_cpu_req | (r_last_grant == c_GRANT_CPU));
        if (w_grant_valid) begin
          if (w_grant_jtag) begin
            w_next_state = r_jtag_wr ? c_JTAG_WR : c_JTAG_RD;
          end else begin
            w_next_state = avs_write ? c_CPU_WR : c_CPU_RD;
          end
        end
      end
      c_CPU_RD:  w_next_state = c_CPU_RD_DATA;
      c_JTAG_RD: w_next_state = c_JTAG_RD_DATA;
      default:   w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    ram_addr        = r_mon_a;
    ram_we          = 1'b0;
    ram_wdata       = r_jtag_wdata;
    avs_waitrequest = 1'b1;
    case (r_state)
      c_CPU_WR: begin
        ram_addr        = avs_address;
        ram_we          = 1'b1;
        ram_wdata       = avs_writedata;
        avs_waitrequest = 1'b0;
      end
      c_CPU_RD:      ram_addr = avs_address;
      c_CPU_RD_DATA: avs_waitrequest = 1'b0;
      c_JTAG_WR:     ram_we = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= c_IDLE;
      r_mon_a      <= '0;
      r_mon_d      <= '0;
      r_jtag_pend  <= 1'b0;
      r_jtag_wr    <= 1'b0;
      r_jtag_wdata <= '0;
      r_last_grant <= c_GRANT_CPU;
      r_error      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_grant_valid) begin
        r_last_grant <= w_grant_jtag ? c_GRANT_JTAG : c_GRANT_CPU;
      end
      if (w_queue) begin
        r_jtag_pend  <= 1'b1;
        r_jtag_wr    <= w_acc_b;
        r_jtag_wdata <= jdo[34:3];
      end else if (w_jtag_done) begin
        r_jtag_pend <= 1'b0;
      end
      if (w_acc_a) begin
        r_mon_a <= jdo[ADDR_W+16:17];
      end else if (w_jtag_done) begin
        r_mon_a <= r_mon_a + ADDR_W'(1);
      end
      if (r_state == c_JTAG_RD_DATA) begin
        r_mon_d <= ram_rdata;
      end
      // A drop in the same cycle as an accepted address load leaves the error set.
      if (w_drop) begin
        r_error <= 1'b1;
      end else if (w_acc_a) begin
        r_error <= 1'b0;
      end
    end
  end

  assign avs_readdata  = ram_rdata;
  assign MonDReg       = r_mon_d;
  assign monitor_ready = ~r_jtag_pend;
  assign monitor_error = r_error;

endmodule
`default_nettype wire

// File: doc/cpu_debug_mem_arbiter.md
Name: cpu_debug_mem_arbiter

Overview:
- System-clock (clk) sequencer and arbiter for the single-port on-chip debug memory (OCI RAM) behind the Nios II debug slave.
- Shares that RAM between two requesters:
  - the JTAG debug path, driven by the take_action_ocimem_* / take_no_action_ocimem_a pulses and jdo from the debug slave sysclk logic;
  - the CPU's Avalon debug-memory slave port.
- Maintains the JTAG address register (MonAReg) with auto-increment.
- Returns read data and status (MonDReg, monitor_ready, monitor_error) to the debug slave capture chain.

Parameters:
- ADDR_W, 8, debug RAM word-address width; MonAReg wraps modulo 2^ADDR_W.
- DATA_W, 32, RAM/Avalon data width; fixed at 32 because MonDReg and jdo[34:3] are 32 bits.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- take_action_ocimem_a  in  1  pulse: load MonAReg <= jdo[ADDR_W+16:17]; if jdo[34]=1, also queue a JTAG read at the new address
- take_no_action_ocimem_a  in  1  pulse: queue a JTAG read at MonAReg
- take_action_ocimem_b  in  1  pulse: queue a JTAG write of jdo[34:3] to MonAReg
- jdo  in  38  JTAG data-out bus, sampled on any of the pulses above
- avs_address  in  ADDR_W  CPU word address
- avs_read  in  1  CPU read request, held until avs_waitrequest=0
- avs_write  in  1  CPU write request, held until avs_waitrequest=0
- avs_writedata  in  32  CPU write data
- avs_readdata  out  32  CPU read data, valid when avs_read=1 and avs_waitrequest=0
- avs_waitrequest  out  1  Avalon stall
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write strobe
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data; one-cycle latency after ram_addr
- MonDReg  out  32  last JTAG read data
- monitor_ready  out  1  1 = no JTAG operation outstanding
- monitor_error  out  1  sticky: JTAG request dropped

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE, MonAReg=0, MonDReg=0, monitor_ready=1, monitor_error=0, last_grant=CPU, jtag_pend=0.
  - Outputs during reset: avs_waitrequest=1, ram_we=0.
- JTAG intake (every cycle, independent of the FSM):
  - Any pulse arriving while jtag_pend=1 is dropped and sets monitor_error=1.
  - If several pulses arrive in one cycle, priority is ocimem_a > no_action_a > ocimem_b; the losing pulses set monitor_error=1.
  - An accepted read or write sets jtag_pend=1 and latches the op type and wdata (jdo[34:3]); monitor_ready is 0 from the next cycle.
  - An address-only load (ocimem_a with jdo[34]=0) updates MonAReg next cycle and never touches the RAM.
  - monitor_error clears on the next accepted take_action_ocimem_a.
- FSM states: IDLE, CPU_WR, CPU_RD, CPU_RD_DATA, JTAG_WR, JTAG_RD, JTAG_RD_DATA.
- IDLE arbitration:
  - cpu_req = avs_read|avs_write.
  - If cpu_req and jtag_pend are both set, grant the requester opposite to last_grant; otherwise grant whichever is requesting.
  - last_grant updates on each grant.
  - If avs_read and avs_write are both set, the access is treated as a write.
- CPU_WR:
  - ram_addr=avs_address, ram_we=1, ram_wdata=avs_writedata, avs_waitrequest=0; next state IDLE.
  - Latency: 2 cycles from request to acceptance.
- CPU_RD:
  - ram_addr=avs_address; next state CPU_RD_DATA.
- CPU_RD_DATA:
  - avs_readdata=ram_rdata, avs_waitrequest=0; next state IDLE (3-cycle read).
- JTAG_WR:
  - ram_addr=MonAReg, ram_we=1, ram_wdata=latched wdata.
  - MonAReg+1 (wrapping), jtag_pend=0, monitor_ready=1 next cycle; next state IDLE.
- JTAG_RD:
  - ram_addr=MonAReg; next state JTAG_RD_DATA.
- JTAG_RD_DATA:
  - MonDReg<=ram_rdata, MonAReg+1 (wrapping), jtag_pend=0, monitor_ready=1; next state IDLE.
- Outside the states above: avs_waitrequest=1, ram_we=0, ram_addr=MonAReg.
- Exactly one RAM access per grant, followed by a mandatory IDLE cycle.
- Wrap-around: MonAReg 2^ADDR_W-1 → 0 after an access.
- An address-load pulse during a JTAG access in progress is dropped (error); MonAReg is unchanged.
- A reset mid-access aborts it: the pending JTAG op is lost and no ram_we is issued after reset asserts.

Test Plan:
- Address load and read: ocimem_a with jdo[24:17]=0x10, jdo[34]=1, RAM[0x10]=0xDEADBEEF -> ram_addr=0x10 two cycles later; MonDReg=0xDEADBEEF; MonAReg=0x11; monitor_ready low 3 cycles then 1.
- Write with wrap: MonAReg=0xFF, ocimem_b with jdo[34:3]=0x12345678 -> one-cycle ram_we at 0xFF with that data; MonAReg=0x00.
- Back-to-back contention: CPU read of 0x05 held high while JTAG reads are continuously re-queued -> grants alternate JTAG, CPU, JTAG (last_grant reset=CPU); CPU waitrequest drops within 6 cycles.
- Dropped request: take_no_action_ocimem_a pulsed twice, 1 cycle apart -> second pulse sets monitor_error=1; only one RAM read occurs; next accepted ocimem_a clears monitor_error.
- CPU-only traffic: write 0xA5A5A5A5 to 0x20 then read 0x20 -> write accepted in cycle 2, read returns 0xA5A5A5A5 with waitrequest=0 in cycle 3 of the read.
- Reset mid-op: assert reset_n=0 in JTAG_RD -> outputs take reset values immediately; MonDReg=0, monitor_ready=1; no RAM access after release until a new request.
